// File: rtl/gfx_plane_mixer.sv
// gfx_plane_mixer: fetches bitplane bytes one character group ahead of the
// beam and mixes prioritised colour layers into registered RGB pixels.
//
// Ports:
//   clk        - the only clock
//   reset_n    - synchronous active-low reset
//   h, v       - horizontal pixel / vertical line counters
//   de         - display enable for the current h
//   vram_addr  - VRAM read address (valid while vram_rd=1)
//   vram_rd    - VRAM read strobe
//   vram_data  - VRAM read data, valid one cycle after vram_rd
//   pal        - per-plane palette bytes, byte i belongs to plane i
//   mask       - per-plane enable
//   prio_swap  - 1 gives layer 0 the highest priority
//   red/green/blue - registered pixel colour
module gfx_plane_mixer #(
  parameter int unsigned LAYERS       = 2,
  parameter int unsigned PLANES       = 3,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned BASE         = 'hEC0,
  parameter int unsigned PLANE_STRIDE = 'h0,
  parameter int unsigned LINE_BYTES   = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [8:0]                 h,
  input  logic [8:0]                 v,
  input  logic                       de,
  output logic [ADDR_W-1:0]          vram_addr,
  output logic                       vram_rd,
  input  logic [7:0]                 vram_data,
  input  logic [LAYERS*PLANES*8-1:0] pal,
  input  logic [LAYERS*PLANES-1:0]   mask,
  input  logic                       prio_swap,
  output logic [7:0]                 red,
  output logic [7:0]                 green,
  output logic [7:0]                 blue
);

  localparam int unsigned NPL = LAYERS * PLANES;

  // Elaboration-time parameter checks
  if (NPL < 1 || NPL > 6) begin : g_npl_check
    $error("gfx_plane_mixer: LAYERS*PLANES must be in 1..6");
  end
  if (LINE_BYTES > 64) begin : g_line_check
    $error("gfx_plane_mixer: LINE_BYTES must not exceed 64");
  end

  logic [2:0] phase;
  logic [5:0] fgrp;
  logic       fetch_ok;

  logic [7:0] staging [NPL];
  logic [7:0] disp    [NPL];

  // Per layer: [5:3] = B/G/R enable bits, [2:0] = B/G/R bright bits
  logic [5:0] lcol [LAYERS];
  logic [7:0] r_c, g_c, b_c;

  // Palette bits 3 and 7 carry no meaning
  logic unused_pal;
  assign unused_pal = ^pal;

  // Fetch target is the next group; 6-bit wrap makes group 63 fetch column 0
  assign phase    = h[2:0];
  assign fgrp     = h[8:3] + 6'd1;
  assign fetch_ok = 32'(fgrp) < LINE_BYTES;

  function automatic logic [7:0] chan(input logic en, input logic br);
    return en ? (br ? 8'hFF : 8'h80) : 8'h00;
  endfunction

  // Read request is decoded straight from h so data lands one phase later
  always_comb begin
    vram_rd   = 1'b0;
    vram_addr = '0;
    if (reset_n && fetch_ok && (32'(phase) < NPL)) begin
      vram_rd   = 1'b1;
      vram_addr = ADDR_W'(BASE + 32'(phase) * PLANE_STRIDE
                          + 32'(v) * LINE_BYTES + 32'(fgrp));
    end
  end

  // Staging capture (plane p lands at the edge ending phase p+1) and
  // hand-over to the display registers at the edge ending phase 7
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NPL); i++) begin
        staging[i] <= 8'h00;
        disp[i]    <= 8'h00;
      end
    end else if (phase == 3'd7) begin
      for (int i = 0; i < int'(NPL); i++) begin
        disp[i]    <= staging[i];
        staging[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < int'(NPL); i++) begin
        if (int'(phase) == i + 1) begin
          staging[i] <= fetch_ok ? vram_data : 8'h00;
        end
      end
    end
  end

  // Layer colour: OR of the palette bytes of lit, enabled planes
  always_comb begin
    for (int l = 0; l < int'(LAYERS); l++) begin
      lcol[l] = 6'h00;
      for (int p = 0; p < int'(PLANES); p++) begin
        if (disp[l*PLANES+p][3'd7 - phase] && mask[l*PLANES+p]) begin
          lcol[l] = lcol[l] | {pal[(l*PLANES+p)*8+4 +: 3],
                               pal[(l*PLANES+p)*8   +: 3]};
        end
      end
    end
  end

  // Per-channel priority: walk lowest to highest priority, nonzero overrides
  always_comb begin
    r_c = 8'h00;
    g_c = 8'h00;
    b_c = 8'h00;
    for (int k = 0; k < int'(LAYERS); k++) begin
      logic [5:0] c;
      logic [7:0] cr, cg, cb;
      c  = prio_swap ? lcol[int'(LAYERS) - 1 - k] : lcol[k];
      cr = chan(c[3], c[0]);
      cg = chan(c[4], c[1]);
      cb = chan(c[5], c[2]);
      if (cr != 8'h00) r_c = cr;
      if (cg != 8'h00) g_c = cg;
      if (cb != 8'h00) b_c = cb;
    end
  end

  // Registered pixel output, blanked outside the display window
  always_ff @(posedge clk) begin
    if (!reset_n || !de) begin
      red   <= 8'h00;
      green <= 8'h00;
      blue  <= 8'h00;
    end else begin
      red   <= r_c;
      green <= g_c;
      blue  <= b_c;
    end
  end

endmodule

// File: tb/tb_gfx_plane_mixer.sv
// Directed bench for gfx_plane_mixer with default parameters.
module tb_gfx_plane_mixer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  h, v;
  logic        de;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [47:0] pal;
  logic [5:0]  mask;
  logic        prio_swap;
  logic [7:0]  red, green, blue;

  always #5 clk = ~clk;

  gfx_plane_mixer dut (
    .clk(clk), .reset_n(reset_n), .h(h), .v(v), .de(de),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .pal(pal), .mask(mask), .prio_swap(prio_swap),
    .red(red), .green(green), .blue(blue)
  );

  // VRAM image, separate per plane so stride-0 reads can still differ
  logic [7:0] img [6][8192];

  always @(posedge clk) begin
    if (vram_rd && int'(h[2:0]) < 6) vram_data <= img[h[2:0]][vram_addr];
    else                             vram_data <= 8'h00;
  end

  logic        rd_log   [512];
  logic [12:0] addr_log [512];
  logic [23:0] rgb_log  [512];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One pixel clock: drive at negedge, log strobe before and rgb after the edge
  task automatic cyc(input logic [8:0] hv, input logic rst);
    h = hv;
    reset_n = rst;
    #1;
    rd_log[hv]   = vram_rd;
    addr_log[hv] = vram_addr;
    @(posedge clk);
    #1;
    rgb_log[hv] = {red, green, blue};
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [47:0] pd;   // byte i = plane i data at column 2, line 0
    logic [47:0] pl;
    logic [5:0]  msk;
    logic        swp;
    logic        dv;
    logic [2:0]  px;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{48'h0000_0000_0080, 48'h0000_0000_0011, 6'h3F, 1'b0, 1'b1, 3'd0, 24'hFF0000};
    vecs[1]  = '{48'h0000_0000_0080, 48'h0000_0000_0011, 6'h3F, 1'b0, 1'b1, 3'd1, 24'h000000};
    vecs[2]  = '{48'h0000_8000_0080, 48'h0000_2000_0010, 6'h3F, 1'b0, 1'b1, 3'd0, 24'h808000};
    vecs[3]  = '{48'h0000_8000_0080, 48'h0000_3000_0010, 6'h3F, 1'b0, 1'b1, 3'd0, 24'h808000};
    vecs[4]  = '{48'h0000_8000_0080, 48'h0000_3000_0010, 6'h3F, 1'b1, 1'b1, 3'd0, 24'h808000};
    vecs[5]  = '{48'h0000_8000_0080, 48'h0000_1000_0011, 6'h3F, 1'b0, 1'b1, 3'd0, 24'h800000};
    vecs[6]  = '{48'h0000_8000_0080, 48'h0000_1000_0011, 6'h3F, 1'b1, 1'b1, 3'd0, 24'hFF0000};
    vecs[7]  = '{48'h0000_8000_0080, 48'h0000_1000_0011, 6'h37, 1'b0, 1'b1, 3'd0, 24'hFF0000};
    vecs[8]  = '{48'h0000_0000_0080, 48'h0000_0000_0011, 6'h3F, 1'b0, 1'b0, 3'd0, 24'h000000};
    vecs[9]  = '{48'h0000_0000_0080, 48'h0000_0000_0011, 6'h00, 1'b0, 1'b1, 3'd0, 24'h000000};
    vecs[10] = '{48'h0000_0080_8000, 48'h0000_0044_2000, 6'h3F, 1'b0, 1'b1, 3'd0, 24'h0080FF};
    vecs[11] = '{48'h0000_0000_0001, 48'h0000_0000_0011, 6'h3F, 1'b0, 1'b1, 3'd7, 24'hFF0000};
    vecs[12] = '{48'h0000_0000_0001, 48'h0000_0000_0011, 6'h3F, 1'b0, 1'b1, 3'd6, 24'h000000};
    vecs[13] = '{48'h4040_0000_0000, 48'h4002_0000_0000, 6'h3F, 1'b0, 1'b1, 3'd1, 24'h000080};
    vecs[14] = '{48'h0010_1000_0000, 48'h0001_1000_0000, 6'h3F, 1'b0, 1'b1, 3'd3, 24'hFF0000};
    vecs[15] = '{48'h0010_1000_0010, 48'h0001_1000_0044, 6'h3F, 1'b0, 1'b1, 3'd3, 24'hFF00FF};

    for (int p = 0; p < 6; p++)
      for (int a = 0; a < 8192; a++) img[p][a] = 8'h00;

    reset_n = 1'b0; h = 9'd0; v = 9'd0; de = 1'b1;
    pal = 48'h0; mask = 6'h3F; prio_swap = 1'b0;
    @(negedge clk);

    // Reset: no reads even in a fetching phase, outputs cleared
    for (int k = 0; k < 3; k++) cyc(9'd8, 1'b0);
    chk("reset_rd", 32'(rd_log[8]), 32'd0);
    chk("reset_rgb", 32'(rgb_log[8]), 32'd0);

    // Table: fetch column 2 during group 1, inspect one pixel of group 2
    foreach (vecs[i]) begin
      for (int p = 0; p < 6; p++) img[p][13'hEC2] = vecs[i].pd[p*8 +: 8];
      pal = vecs[i].pl; mask = vecs[i].msk; prio_swap = vecs[i].swp; v = 9'd0;
      for (int k = 8; k < 24; k++) begin
        de = (k >= 16) ? vecs[i].dv : 1'b1;
        cyc(9'(k), 1'b1);
      end
      chk($sformatf("vec%0d", i), 32'(rgb_log[16 + int'(vecs[i].px)]), 32'(vecs[i].exp_rgb));
    end
    de = 1'b1;

    // Fetch strobes/addresses of the last table run (line 0, column 2)
    for (int k = 8; k < 16; k++) begin
      if (k < 14) chk($sformatf("fetch_h%0d", k), {18'd0, rd_log[k], addr_log[k]}, {18'd0, 1'b1, 13'hEC2});
      else        chk($sformatf("fetch_h%0d", k), 32'(rd_log[k]), 32'd0);
    end

    // Column 24 does not exist: no read, blank group even if VRAM has data
    begin
      logic rd_any;
      for (int p = 0; p < 6; p++) img[p][13'hED8] = 8'hFF;
      pal = 48'h11; mask = 6'h3F; prio_swap = 1'b0; v = 9'd0;
      for (int k = 184; k < 200; k++) cyc(9'(k), 1'b1);
      rd_any = 1'b0;
      for (int k = 184; k < 192; k++) rd_any = rd_any | rd_log[k];
      chk("f24_no_rd", 32'(rd_any), 32'd0);
      for (int k = 192; k < 200; k++) chk($sformatf("f24_px%0d", k), 32'(rgb_log[k]), 32'd0);
      for (int p = 0; p < 6; p++) img[p][13'hED8] = 8'h00;
    end

    // Group 63 on line 5 fetches column 0 for the next pass
    img[0][13'hF38] = 8'h80;
    pal = 48'h11; v = 9'd5;
    for (int k = 504; k < 512; k++) cyc(9'(k), 1'b1);
    for (int k = 0; k < 8; k++) cyc(9'(k), 1'b1);
    for (int k = 504; k < 510; k++)
      chk($sformatf("wrap_rd_h%0d", k), {18'd0, rd_log[k], addr_log[k]}, {18'd0, 1'b1, 13'hF38});
    chk("wrap_px0", 32'(rgb_log[0]), 32'hFF0000);
    chk("wrap_px1", 32'(rgb_log[1]), 32'h000000);

    // Reset during phases 3..5 of group 3, released at phase 6
    v = 9'd0; pal = 48'h11;
    for (int c = 0; c < 24; c++) img[0][13'hEC0 + 13'(c)] = 8'hFF;
    for (int k = 16; k < 48; k++) cyc(9'(k), !(k >= 27 && k <= 29));
    chk("rst_before", 32'(rgb_log[26]), 32'hFF0000);
    chk("rst_rd_off", 32'(rd_log[27]), 32'd0);
    for (int k = 27; k < 40; k++) chk($sformatf("rst_zero_h%0d", k), 32'(rgb_log[k]), 32'd0);
    chk("rst_resume_h40", 32'(rgb_log[40]), 32'hFF0000);
    chk("rst_resume_h47", 32'(rgb_log[47]), 32'hFF0000);

    // Palette is taken at display time, not at fetch time
    img[0][13'hEC2] = 8'h80;
    for (int k = 8; k < 24; k++) begin
      pal = (k < 16) ? 48'h0 : 48'h11;
      cyc(9'(k), 1'b1);
    end
    chk("live_pal_px16", 32'(rgb_log[16]), 32'hFF0000);
    chk("live_pal_px17", 32'(rgb_log[17]), 32'h000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gfx_plane_mixer.md
GFX_PLANE_MIXER -- requirements
Module: gfx_plane_mixer

Interface
REQ-001 SHALL provide parameter LAYERS, default 2: number of colour layers; layer LAYERS-1 is foreground.
REQ-002 SHALL provide parameter PLANES, default 3: bitplanes per layer. NPL = LAYERS*PLANES SHALL be 1..6; elaboration fails otherwise.
REQ-003 SHALL provide parameter ADDR_W, default 13: VRAM address width.
REQ-004 SHALL provide parameter BASE, default 'hEC0: VRAM byte address of plane 0, line 0, column 0.
REQ-005 SHALL provide parameter PLANE_STRIDE, default 'h0: address offset between consecutive planes. Plane index = layer*PLANES + plane.
REQ-006 SHALL provide parameter LINE_BYTES, default 24: bytes per line per plane; maximum 64.
REQ-007 SHALL have port clk, input, 1: the only clock.
REQ-008 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-009 SHALL have port h, input, 9: horizontal pixel counter.
REQ-010 SHALL have port v, input, 9: vertical line counter.
REQ-011 SHALL have port de, input, 1: display enable for the current h.
REQ-012 SHALL have port vram_addr, output, ADDR_W: VRAM read address.
REQ-013 SHALL have port vram_rd, output, 1: read strobe.
REQ-014 SHALL have port vram_data, input, 8: read data, valid exactly 1 cycle after vram_rd.
REQ-015 SHALL have port pal, input, NPL*8: per-plane palette bytes; byte i belongs to plane i.
REQ-016 SHALL have port mask, input, NPL: plane enable; bit i gates plane i.
REQ-017 SHALL have port prio_swap, input, 1: when 1, layer 0 gets highest priority.
REQ-018 SHALL have ports red, green and blue, output, 8 each: registered pixel colour.

Function
REQ-019 Phase SHALL be h[2:0] and group SHALL be h[8:3]. While in group g, the block fetches group f = (g+1) mod 64, so group 63 fetches column 0.
REQ-020 At phase p < NPL with f < LINE_BYTES: vram_rd=1 and vram_addr = BASE + p*PLANE_STRIDE + v*LINE_BYTES + f, truncated to ADDR_W. vram_rd SHALL be 0 at all other times.
REQ-021 vram_data SHALL be captured into staging[p] at the clock edge ending phase p+1.
REQ-022 When f >= LINE_BYTES, no read is issued and staging[p] SHALL load 8'h00.
REQ-023 At the edge ending phase 7, all staging bytes SHALL transfer to the display registers, and the staging bytes SHALL then clear.
REQ-024 The display pixel bit for plane i SHALL be disp[i][7-h[2:0]], i.e. MSB first, ANDed with mask[i].
REQ-025 Layer colour SHALL be the bitwise OR of pal[i] over set pixel bits in that layer.
REQ-026 Per layer: channel R uses colour bits 4/0, G uses bits 5/1, B uses bits 6/2. Value = enable bit ? (bright bit ? 8'hFF : 8'h80) : 8'h00.
REQ-027 Priority SHALL be resolved per channel: the highest-priority layer with a nonzero channel wins; if all are zero, the output is 0. Order is LAYERS-1 down to 0, reversed when prio_swap=1.
REQ-028 red/green/blue SHALL be registered. The value presented after edge k SHALL correspond to h sampled at edge k, and SHALL be 0 if de=0 at that edge.
REQ-029 Pixel x SHALL be correct only if h stepped by 1 through the whole of group (x>>3)-1. A non-consecutive h jump SHALL NOT hang the block; it yields stale or zero pixels for at most 2 groups.
REQ-030 mask, pal and prio_swap SHALL be sampled live at the output stage, not latched at fetch time.
REQ-031 The block SHALL contain no state beyond staging, display and output registers, and SHALL require no line-start strobe.

Reset
REQ-032 While reset_n=0 at an edge, the block SHALL clear red/green/blue, all staging and all display registers, and drive vram_rd=0.
REQ-033 The first group displayed after reset release SHALL be the first group whose full fetch (phases 0..7) completed after release. Earlier groups SHALL output 0.
REQ-034 Reset asserted mid-group SHALL abort the fetch with no partial transfer.

Verification
REQ-035 Setup: v=0, h=8..15, de=1, mask=6'h3F, pal0=8'h11, other pal=0, VRAM plane0 col2=8'h80, other reads 0. Expected: pixel 16 red=FF, green=blue=0; pixel 17 rgb=0.
REQ-036 Setup: plane0 pal=8'h10 and plane3 pal=8'h20, both bits set at pixel 16. Expected with prio_swap=0: red=80, green=80. Then set plane3 pal=8'h30 and repeat with prio_swap 0 and 1. Expected: red=80 from layer1 when prio_swap=0, red=80 from layer0 when prio_swap=1; green=80 in both cases.
REQ-037 Setup: h=184..191, i.e. group 23 fetching f=24. Expected: no vram_rd, and pixels 192..199 output 0.
REQ-038 Setup: h=504..511 on line v=5. Expected: reads at addresses EC0+5*24+0 = 'hF38 for planes 0..5 with PLANE_STRIDE=0, and pixel 0 of the following pass correct.
REQ-039 Setup: reset_n=0 at phase 3, released at phase 6. Expected: outputs 0 through the next group, and correct data from the second full group onward.
REQ-040 Setup: de=0 with nonzero pixel data, and mask=0. Expected: rgb=0 in both cases, and vram_rd activity unchanged.
